rvfi_retire_sequencer: RTL and testbench

- Sits between the core's retirement stage and the RVFI tracer outputs.
- Accepts one packed retirement record per cycle through a valid/ready handshake and buffers it in a small FIFO.
- Stamps each accepted record with a monotonically increasing 64-bit order number, then presents records in order to the trace sink through a valid/ready handshake.
- Back-pressures the core when the buffer is full, and can globally gate tracing.

---
 rtl/rvfi_retire_sequencer_pkg.sv | 28 ++
 rtl/rvfi_retire_sequencer_if.sv | 28 ++
 rtl/rvfi_retire_sequencer_fifo.sv | 60 ++++++
 rtl/rvfi_retire_sequencer.sv | 77 +++++++
 tb/tb_rvfi_retire_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_retire_sequencer_pkg.sv
// Shared types for the RVFI retire sequencer: the packed retirement record and its field widths.
package rvfi_seq_pkg;

    localparam int XLEN            = 32;
    localparam int REG_AW          = 5;
    localparam int WMASK_W         = 4;
    localparam int DEFAULT_ORDER_W = 64;

    // insn sits in the most significant bits of the packed record
    typedef struct packed {
        logic [XLEN-1:0]    insn;
        logic [REG_AW-1:0]  rs1_addr;
        logic [REG_AW-1:0]  rs2_addr;
        logic [REG_AW-1:0]  rd_addr;
        logic [XLEN-1:0]    rs1_rdata;
        logic [XLEN-1:0]    rs2_rdata;
        logic [XLEN-1:0]    rd_wdata;
        logic [XLEN-1:0]    pc_rdata;
        logic [XLEN-1:0]    pc_wdata;
        logic [XLEN-1:0]    mem_addr;
        logic [WMASK_W-1:0] mem_wmask;
        logic [XLEN-1:0]    mem_rdata;
        logic [XLEN-1:0]    mem_wdata;
    } rvfi_rec_t;

    localparam int REC_W = $bits(rvfi_rec_t);

endpackage

// File: rtl/rvfi_retire_sequencer_if.sv
// Retirement-side and trace-side handshake bundle of the sequencer.
// Both sides use valid/ready: a beat transfers on a rising clock edge where valid & ready are both high;
// valid, once raised, is held with stable payload until that transfer happens.
interface rvfi_retire_sequencer_if #(
    parameter int ORDER_W = rvfi_seq_pkg::DEFAULT_ORDER_W
);
    import rvfi_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    rvfi_rec_t          in_rec;
    logic               out_valid;
    logic               out_ready;
    rvfi_rec_t          out_rec;
    logic [ORDER_W-1:0] out_order;

    // master = core and trace sink, slave = sequencer
    modport master (
        output in_valid, in_rec, out_ready,
        input  in_ready, out_valid, out_rec, out_order
    );

    modport slave (
        input  in_valid, in_rec, out_ready,
        output in_ready, out_valid, out_rec, out_order
    );

endinterface

// File: rtl/rvfi_retire_sequencer_fifo.sv
// Register FIFO holding stamped retirement records; the head entry is read straight from storage.
module rvfi_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   level_q;
    logic            do_push;
    logic            do_pop;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem[rd_ptr];

    // A push into a full FIFO is only taken when the head leaves in the same cycle
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (!do_push && do_pop) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// Stamps retired records with an order number and buffers them for the RVFI tracer.
// Build option RVFI_SEQ_DROP_EN: never stall the core, drop records on overflow and count them in drop_cnt.
module rvfi_retire_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ORDER_W = DEFAULT_ORDER_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    trace_en,
    rvfi_retire_sequencer_if.slave  bus,
    output logic [$clog2(DEPTH):0]  level
`ifdef RVFI_SEQ_DROP_EN
    ,
    output logic [31:0]             drop_cnt
`endif
);
    localparam int W = ORDER_W + REC_W;

    logic               accept;
    logic               pop;
    logic               fifo_push;
    logic               full;
    logic               empty;
    logic [ORDER_W-1:0] order_q;
    logic [W-1:0]       fifo_rdata;

    assign accept    = bus.in_valid & bus.in_ready;
    assign pop       = bus.out_valid & bus.out_ready;
    assign fifo_push = accept & trace_en;
    assign bus.out_valid = ~empty;
    assign {bus.out_order, bus.out_rec} = fifo_rdata;

    // Every accept consumes an order number, even when the record itself is not kept
    always_ff @(posedge clock) begin
        if (reset) begin
            order_q <= '0;
        end else if (accept) begin
            order_q <= order_q + 1'b1;
        end
    end

`ifdef RVFI_SEQ_DROP_EN
    logic drop;

    assign bus.in_ready = 1'b1;
    assign drop         = fifo_push & full & ~pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 32'hFFFF_FFFF) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end
`else
    // Registered-level based: a same-cycle pop does not open the input
    assign bus.in_ready = ~full;
`endif

    rvfi_seq_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({order_q, bus.in_rec}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
// Directed-plus-random bench for rvfi_retire_sequencer against a queue-based reference model.
module tb_rvfi_retire_sequencer;
    import rvfi_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int ORDER_W = 64;
    localparam int W       = ORDER_W + REC_W;
    localparam int CW      = 384;

    logic                   clock;
    logic                   reset;
    logic                   trace_en;
    logic [$clog2(DEPTH):0] level;
`ifdef RVFI_SEQ_DROP_EN
    logic [31:0]            drop_cnt;
    logic [31:0]            exp_drop;
`endif

    rvfi_retire_sequencer_if #(.ORDER_W(ORDER_W)) bus ();

    rvfi_retire_sequencer #(
        .DEPTH   (DEPTH),
        .ORDER_W (ORDER_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .trace_en (trace_en),
        .bus      (bus),
        .level    (level)
`ifdef RVFI_SEQ_DROP_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    // clock/reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard: {order, record} entries the sink must see, oldest first
    logic [W-1:0]       exp_q [$];
    logic [ORDER_W-1:0] next_order;
    int                 n_vec;
    int                 n_err;
    bit                 pending;
    rvfi_rec_t          tmp_rec;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rvfi_rec_t rand_rec();
        logic [REC_W-1:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) begin
            v = (v << 32) | REC_W'($urandom());
        end
        return rvfi_rec_t'(v);
    endfunction

    // One clock: compare outputs to the model, advance the model across the edge, refresh the offer.
    task automatic cycle();
        logic [W-1:0] head;
        bit           exp_ready;
        bit           acc;
        bit           pop_ok;
        bit           was_full;
        int           sz;
        sz = exp_q.size();
`ifdef RVFI_SEQ_DROP_EN
        exp_ready = 1'b1;
        check("drop_cnt", drop_cnt, exp_drop);
`else
        exp_ready = (sz < DEPTH);
`endif
        check("in_ready", bus.in_ready, exp_ready);
        check("out_valid", bus.out_valid, sz != 0);
        check("level", level, sz);
        if (sz != 0) begin
            head = exp_q[0];
            check("out_order", bus.out_order, head[W-1 -: ORDER_W]);
            check("out_rec", bus.out_rec, head[REC_W-1:0]);
        end
        acc      = bus.in_valid && exp_ready;
        pop_ok   = (sz != 0) && bus.out_ready;
        was_full = (sz == DEPTH);
        @(posedge clock);
        if (reset) begin
            exp_q.delete();
            next_order = '0;
`ifdef RVFI_SEQ_DROP_EN
            exp_drop = '0;
`endif
            acc = 1'b0;
        end else begin
            if (pop_ok) void'(exp_q.pop_front());
            if (acc) begin
                if (trace_en) begin
                    if (!was_full || pop_ok) begin
                        exp_q.push_back({next_order, bus.in_rec});
                    end
`ifdef RVFI_SEQ_DROP_EN
                    else if (exp_drop != 32'hFFFF_FFFF) begin
                        exp_drop = exp_drop + 1;
                    end
`endif
                end
                next_order = next_order + 1;
            end
        end
        pending = bus.in_valid && !acc && !reset;
        @(negedge clock);
        if (acc) bus.in_rec = rand_rec();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && exp_q.size() != 0; i++) cycle();
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        pending     = 1'b0;
        next_order  = '0;
`ifdef RVFI_SEQ_DROP_EN
        exp_drop    = '0;
`endif
        reset         = 1'b1;
        trace_en      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_rec    = rand_rec();
        repeat (2) @(posedge clock);
        @(negedge clock);

        // reset state
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_level", level, 0);
        check("rst_out_rec", bus.out_rec, 0);
        check("rst_out_order", bus.out_order, 0);
        reset = 1'b0;

        // single accept of a NOP
        tmp_rec      = rand_rec();
        tmp_rec.insn = 32'h0000_0013;
        bus.in_rec   = tmp_rec;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        tmp_rec = bus.out_rec;
        check("nop_valid", bus.out_valid, 1'b1);
        check("nop_order", bus.out_order, 0);
        check("nop_insn", tmp_rec.insn, 32'h0000_0013);
        drain();
        check("nop_level", level, 0);

        // fill to DEPTH with the sink stalled, fifth offer held
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (4) cycle();
        check("fill_level", level, DEPTH);
`ifndef RVFI_SEQ_DROP_EN
        check("fill_in_ready", bus.in_ready, 1'b0);
`endif
        repeat (2) cycle();
        bus.out_ready = 1'b1;
        while (pending) cycle();
        drain();

        // streaming: level stays at one, orders without gaps
        do_reset();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        for (int i = 0; i < 20; i++) begin
            check("stream_order", bus.out_order, i);
            cycle();
        end
        check("stream_level", level, 1);
        drain();

        // trace gating on accepts 2 and 3 of 5
        do_reset();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            trace_en = !(k == 1 || k == 2);
            cycle();
        end
        trace_en = 1'b1;
        drain();
        check("gate_next_order", next_order, 5);

        // reset with three records buffered
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (3) cycle();
        bus.in_valid = 1'b0;
        check("pre_rst_level", level, 3);
        do_reset();
        check("post_rst_valid", bus.out_valid, 1'b0);
        check("post_rst_level", level, 0);
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        check("post_rst_order", bus.out_order, 0);
        drain();

`ifdef RVFI_SEQ_DROP_EN
        // overflow drops three of seven, order keeps counting
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (7) cycle();
        bus.in_valid = 1'b0;
        cycle();
        check("drop_level", level, DEPTH);
        check("drop_count", drop_cnt, 3);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        drain();
        check("drop_next_order", next_order, 8);
`endif

        // random traffic with occasional reset
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!pending) bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            trace_en      = ($urandom_range(0, 4) != 0);
            reset         = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset    = 1'b0;
        trace_en = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
